// File: rtl/mmio_hub_if.sv
// mmio_hub_if: datapath, dmem, console sink and test-status signals of the
// MMIO hub. The hub takes the slave view; the CPU/dmem/sink side takes master.
//
// Handshake (console sink): console_valid && console_ready at a rising clk
// edge transfers console_data. While console_valid is high and
// console_ready is low, console_data holds its value. console_valid never
// depends combinationally on console_ready.
interface mmio_hub_if #(
  parameter int XLEN          = 32,
  parameter int CONSOLE_WIDTH = 8
);
  logic [XLEN-1:0]          cpu_addr;
  logic [XLEN-1:0]          cpu_wdata;
  logic [XLEN-1:0]          cpu_wmask;
  logic                     cpu_we;
  logic [XLEN-1:0]          cpu_rdata;
  logic [XLEN-1:0]          mem_addr;
  logic [XLEN-1:0]          mem_wdata;
  logic [XLEN-1:0]          mem_wmask;
  logic                     mem_we;
  logic [XLEN-1:0]          mem_rdata;
  logic [CONSOLE_WIDTH-1:0] console_data;
  logic                     console_valid;
  logic                     console_ready;
  logic                     console_overflow;
  logic                     test_passed;
  logic                     test_failed;
  logic [XLEN-1:0]          test_code;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wmask, cpu_we, mem_rdata, console_ready,
    output cpu_rdata, mem_addr, mem_wdata, mem_wmask, mem_we,
           console_data, console_valid, console_overflow,
           test_passed, test_failed, test_code
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wmask, cpu_we, mem_rdata, console_ready,
    input  cpu_rdata, mem_addr, mem_wdata, mem_wmask, mem_we,
           console_data, console_valid, console_overflow,
           test_passed, test_failed, test_code
  );
endinterface

// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O decoder between the datapath data port and dmem.
// Peripherals: buffered console transmit FIFO, console status register,
// sticky pass/fail test-status register, and an optional cycle counter
// enabled by defining MMIO_CYCLE_COUNTER_EN. Anything outside the MMIO
// words passes through to dmem unchanged.
module mmio_hub #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR   = XLEN'(32'h1000_0000),
  parameter logic [XLEN-1:0] TEST_STAT_ADDR = XLEN'(32'h2000_0000),
  parameter logic [XLEN-1:0] PASS_MAGIC     = XLEN'(123456789),
  parameter int              CONSOLE_DEPTH  = 8,
  parameter int              CONSOLE_WIDTH  = 8
) (
  input logic       clk,
  input logic       reset,
  mmio_hub_if.slave bus
);
  localparam int AW    = $clog2(CONSOLE_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [XLEN-1:0] CONSOLE_STAT_ADDR = CONSOLE_ADDR + XLEN'(4);
  localparam logic [XLEN-1:0] CYCLE_ADDR        = TEST_STAT_ADDR + XLEN'(8);

  // Address decode
  logic hit_con_data, hit_con_stat, hit_test, hit_cyc, hit;

  // Console FIFO state
  logic [CONSOLE_WIDTH-1:0] fifo_q [CONSOLE_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     overflow;
  logic                     full, empty, push_req, push_ok, pop;

  // Test status state
  logic            passed, failed;
  logic [XLEN-1:0] code;
  logic [XLEN-1:0] stat_word;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [XLEN-1:0] cycle_q;
`endif

  assign hit_con_data = (bus.cpu_addr == CONSOLE_ADDR);
  assign hit_con_stat = (bus.cpu_addr == CONSOLE_STAT_ADDR);
  assign hit_test     = (bus.cpu_addr == TEST_STAT_ADDR);
`ifdef MMIO_CYCLE_COUNTER_EN
  assign hit_cyc      = (bus.cpu_addr == CYCLE_ADDR);
`else
  assign hit_cyc      = 1'b0;
`endif
  assign hit = hit_con_data | hit_con_stat | hit_test | hit_cyc;

  // dmem side: address always forwarded, stores suppressed on an MMIO hit
  assign bus.mem_addr  = bus.cpu_addr;
  assign bus.mem_we    = bus.cpu_we & ~hit;
  assign bus.mem_wdata = hit ? '0 : bus.cpu_wdata;
  assign bus.mem_wmask = hit ? '0 : bus.cpu_wmask;

  // FIFO control: a push into a full FIFO survives only if the head leaves
  // on the same edge; an empty FIFO cannot pop, so no bypass path exists.
  assign full     = (count == CNT_W'(CONSOLE_DEPTH));
  assign empty    = (count == '0);
  assign pop      = ~empty & bus.console_ready;
  assign push_req = bus.cpu_we & hit_con_data;
  assign push_ok  = push_req & (~full | pop);

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only visible through count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr] <= bus.cpu_wdata[CONSOLE_WIDTH-1:0];
  end

  assign bus.console_valid    = ~empty;
  assign bus.console_data     = empty ? '0 : fifo_q[rd_ptr];
  assign bus.console_overflow = overflow;

  // Sticky test status: first failure value is kept, flags clear only on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      passed <= 1'b0;
      failed <= 1'b0;
      code   <= '0;
    end else if (bus.cpu_we && hit_test) begin
      if (bus.cpu_wdata == PASS_MAGIC) begin
        passed <= 1'b1;
      end else if (!failed) begin
        failed <= 1'b1;
        code   <= bus.cpu_wdata;
      end
    end
  end

  assign bus.test_passed = passed;
  assign bus.test_failed = failed;
  assign bus.test_code   = code;

`ifdef MMIO_CYCLE_COUNTER_EN
  // Free-running cycle counter; a store loads it instead of incrementing
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cycle_q <= '0;
    else if (bus.cpu_we && hit_cyc) cycle_q <= bus.cpu_wdata;
    else                          cycle_q <= cycle_q + XLEN'(1);
  end
`endif

  // Console status word: full, empty, overflow, count in [15:8]
  always_comb begin
    stat_word       = '0;
    stat_word[0]    = full;
    stat_word[1]    = empty;
    stat_word[2]    = overflow;
    stat_word[15:8] = 8'(count);
  end

  // Load data: MMIO register on a hit, otherwise dmem
  always_comb begin
    bus.cpu_rdata = bus.mem_rdata;
    if (hit_con_data)      bus.cpu_rdata = '0;
    else if (hit_con_stat) bus.cpu_rdata = stat_word;
    else if (hit_test)     bus.cpu_rdata = {{(XLEN-2){1'b0}}, failed, passed};
`ifdef MMIO_CYCLE_COUNTER_EN
    else if (hit_cyc)      bus.cpu_rdata = cycle_q;
`endif
  end
endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: self-checking bench for mmio_hub (default parameters).
// Console entries are pushed to an expected queue when stores are driven and
// popped when the sink accepts them; a small word memory stands in for dmem.
module tb_mmio_hub;
  localparam logic [31:0] CON    = 32'h1000_0000;
  localparam logic [31:0] CON_ST = 32'h1000_0004;
  localparam logic [31:0] TST    = 32'h2000_0000;
  localparam logic [31:0] CYC    = 32'h2000_0008;
  localparam logic [31:0] MAGIC  = 32'd123456789;
  localparam int          DEPTH  = 8;

  logic clk;
  logic reset;
  mmio_hub_if bus ();

  mmio_hub dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: masked word writes, combinational reads
  logic [31:0] dmem [0:255];
  initial for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
  always @(posedge clk)
    if (bus.mem_we)
      dmem[bus.mem_addr[9:2]] <= (dmem[bus.mem_addr[9:2]] & ~bus.mem_wmask) |
                                 (bus.cpu_wdata & bus.mem_wmask);
  assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];

  // Scoreboard
  logic [7:0] exp_q[$];
  int         model_count;
  int         total;
  int         bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Sink monitor: sampled at negedge, a pop occurs at the following posedge
  always @(negedge clk) begin
    if (!reset) begin
      check("console_valid", {31'b0, bus.console_valid}, {31'b0, model_count != 0});
      if (bus.console_valid) begin
        if (exp_q.size() == 0) begin
          check("sink_unexpected", {24'b0, bus.console_data}, 32'hFFFF_FFFF);
        end else begin
          check("console_data", {24'b0, bus.console_data}, {24'b0, exp_q[0]});
          if (bus.console_ready) begin
            void'(exp_q.pop_front());
            model_count--;
          end
        end
      end
    end
  end

  // Driver tasks; all start and end 1 time unit after a rising edge
  task automatic cpu_idle();
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_wmask = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    model_count = 0;
    cpu_idle();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] m, output logic we_o,
                           output logic [31:0] wd_o, output logic [31:0] wm_o);
    logic accept;
    accept = 1'b0;
    if (a == CON) begin
      if (model_count < DEPTH || (bus.console_ready && model_count > 0)) begin
        accept = 1'b1;
        exp_q.push_back(d[7:0]);
      end
    end
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wmask = m;
    bus.cpu_we    = 1'b1;
    #1;
    we_o = bus.mem_we;
    wd_o = bus.mem_wdata;
    wm_o = bus.mem_wmask;
    @(posedge clk);
    if (accept) model_count++;
    #1 cpu_idle();
  endtask

  task automatic cpu_load(input logic [31:0] a, output logic [31:0] d);
    bus.cpu_addr = a;
    bus.cpu_we   = 1'b0;
    #1 d = bus.cpu_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int exp_cycles, input string tag);
    int n;
    n = 0;
    bus.console_ready = 1'b1;
    while (bus.console_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check(tag, n, exp_cycles);
    check({tag, "_left"}, exp_q.size(), 0);
    bus.console_ready = 1'b0;
  endtask

  logic [31:0] we_s, wd_s, wm_s, rd;
  logic        we_b;

  initial begin
    total = 0;
    bad = 0;
    model_count = 0;
    bus.cpu_addr = 32'h0;
    bus.console_ready = 1'b0;
    cpu_idle();
    reset = 1'b1;
    #23;
    check("rst_valid", {31'b0, bus.console_valid}, 32'h0);
    check("rst_data", {24'b0, bus.console_data}, 32'h0);
    check("rst_ovf", {31'b0, bus.console_overflow}, 32'h0);
    check("rst_pass", {31'b0, bus.test_passed}, 32'h0);
    check("rst_fail", {31'b0, bus.test_failed}, 32'h0);
    check("rst_code", bus.test_code, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single console store: valid next cycle, dmem never written
    cpu_store(CON, 32'h0000_0041, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("con_mem_we", {31'b0, we_b}, 32'h0);
    check("con_mem_wdata", wd_s, 32'h0);
    check("con_mem_wmask", wm_s, 32'h0);
    check("con_valid_next", {31'b0, bus.console_valid}, 32'h1);
    check("con_data_next", {24'b0, bus.console_data}, 32'h41);
    check("con_mem_we_after", {31'b0, bus.mem_we}, 32'h0);
    cpu_load(CON, rd);
    check("con_data_read", rd, 32'h0);
    drain(1, "drain_one");

    // Nine stores into a depth-8 FIFO: last one dropped
    for (int i = 0; i < 9; i++)
      cpu_store(CON, 32'h30 + i, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("ovf_set", {31'b0, bus.console_overflow}, 32'h1);
    cpu_load(CON_ST, rd);
    check("stat_full", rd, 32'h0000_0805);
    cpu_store(CON_ST, 32'hFFFF_FFFF, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("stat_wr_mem_we", {31'b0, we_b}, 32'h0);
    cpu_load(CON_ST, rd);
    check("stat_wr_ignored", rd, 32'h0000_0805);
    drain(8, "drain_eight");
    cpu_load(CON_ST, rd);
    check("stat_empty_ovf", rd, 32'h0000_0006);

    // Full FIFO with simultaneous push and pop: accepted, no overflow
    do_reset();
    for (int i = 0; i < 8; i++)
      cpu_store(CON, 32'h30 + i, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    bus.console_ready = 1'b1;
    cpu_store(CON, 32'h99, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    bus.console_ready = 1'b0;
    check("pp_ovf", {31'b0, bus.console_overflow}, 32'h0);
    cpu_load(CON_ST, rd);
    check("pp_stat", rd, 32'h0000_0801);
    drain(8, "drain_pp");

    // Test status: first failure latched, pass still recorded
    cpu_store(TST, 32'd5, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("tst_mem_we", {31'b0, we_b}, 32'h0);
    cpu_store(TST, 32'd7, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    cpu_store(TST, MAGIC, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("tst_failed", {31'b0, bus.test_failed}, 32'h1);
    check("tst_code", bus.test_code, 32'd5);
    check("tst_passed", {31'b0, bus.test_passed}, 32'h1);
    cpu_load(TST, rd);
    check("tst_read", rd, 32'h3);

    // Asynchronous reset mid-cycle clears flags and flushes the FIFO
    cpu_store(CON, 32'h61, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    cpu_store(CON, 32'h62, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    #2 reset = 1'b1;
    exp_q.delete();
    model_count = 0;
    #1;
    check("arst_pass", {31'b0, bus.test_passed}, 32'h0);
    check("arst_fail", {31'b0, bus.test_failed}, 32'h0);
    check("arst_code", bus.test_code, 32'h0);
    check("arst_valid", {31'b0, bus.console_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    cpu_load(CON_ST, rd);
    check("arst_stat", rd, 32'h0000_0002);

    // Pass first, then a failure still latches its code
    cpu_store(TST, MAGIC, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("pf_fail_clear", {31'b0, bus.test_failed}, 32'h0);
    cpu_store(TST, 32'h77, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("pf_code", bus.test_code, 32'h77);
    cpu_load(TST, rd);
    check("pf_read", rd, 32'h3);

    // dmem pass-through with full and partial masks
    cpu_store(32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("dm_we", {31'b0, we_b}, 32'h1);
    check("dm_wdata", wd_s, 32'hDEAD_BEEF);
    check("dm_wmask", wm_s, 32'hFFFF_FFFF);
    cpu_load(32'h0000_0100, rd);
    check("dm_load", rd, 32'hDEAD_BEEF);
    cpu_store(32'h0000_0100, 32'h1234_5678, 32'h0000_FFFF, we_b, wd_s, wm_s);
    check("dm_wmask_part", wm_s, 32'h0000_FFFF);
    cpu_load(32'h0000_0100, rd);
    check("dm_load_part", rd, 32'hDEAD_5678);

    // Random dmem traffic away from the MMIO words
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, d;
      a = {22'h0, 8'($urandom_range(64, 200)), 2'b00};
      d = $urandom;
      cpu_store(a, d, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
      check("rnd_mem_we", {31'b0, we_b}, 32'h1);
      cpu_load(a, rd);
      check("rnd_load", rd, d);
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    // Counter load, then increments and wrap on consecutive cycles
    cpu_store(CYC, 32'hFFFF_FFFE, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("cyc_mem_we", {31'b0, we_b}, 32'h0);
    bus.cpu_addr = CYC;
    #1 check("cyc_load", bus.cpu_rdata, 32'hFFFF_FFFE);
    @(posedge clk);
    #1 check("cyc_ones", bus.cpu_rdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 check("cyc_wrap", bus.cpu_rdata, 32'h0);
    @(posedge clk);
    #1;
`else
    // Without the counter the word is plain dmem
    cpu_store(CYC, 32'hFFFF_FFFE, 32'hFFFF_FFFF, we_b, wd_s, wm_s);
    check("cyc_mem_we", {31'b0, we_b}, 32'h1);
    check("cyc_mem_wdata", wd_s, 32'hFFFF_FFFE);
    cpu_load(CYC, rd);
    check("cyc_dmem", rd, 32'hFFFF_FFFE);
`endif

    check("final_ovf", {31'b0, bus.console_overflow}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
- Memory-mapped I/O decoder between the datapath's data port and dmem.
- Generalises the fixed console/test-status store decode into parametrised peripherals:
  - a buffered console transmit channel with a valid/ready sink handshake,
  - a readable console status register,
  - a sticky pass/fail test-status register with failure code,
  - an optional cycle counter.
- Every access outside the MMIO windows passes through to dmem unchanged.

Parameters:
- XLEN, 32, data/address width.
- CONSOLE_ADDR, 32'h1000_0000, console data register; status register at CONSOLE_ADDR+4.
- TEST_STAT_ADDR, 32'h2000_0000, test-status register; cycle counter at TEST_STAT_ADDR+8.
- PASS_MAGIC, 123456789, value that marks a test as passed.
- CONSOLE_DEPTH, 8, console FIFO entries; power of two, ≥2.
- CONSOLE_WIDTH, 8, bits per console entry (taken from wdata[CONSOLE_WIDTH-1:0]).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  XLEN  datapath data address.
- cpu_wdata  in  XLEN  datapath store data.
- cpu_wmask  in  XLEN  datapath byte/bit write mask.
- cpu_we  in  1  datapath store strobe.
- cpu_rdata  out  XLEN  load data returned to datapath.
- mem_addr  out  XLEN  dmem address (always equals cpu_addr).
- mem_wdata  out  XLEN  dmem write data.
- mem_wmask  out  XLEN  dmem write mask.
- mem_we  out  1  dmem write enable.
- mem_rdata  in  XLEN  dmem read data.
- console_data  out  CONSOLE_WIDTH  head of console FIFO.
- console_valid  out  1  FIFO non-empty.
- console_ready  in  1  sink accepts head this cycle.
- console_overflow  out  1  sticky; a console write was dropped.
- test_passed  out  1  sticky pass flag.
- test_failed  out  1  sticky fail flag.
- test_code  out  XLEN  first failure value written.

Behaviour:
- Clocking and reset:
  - Clock is clk. Reset is asynchronous, active-high.
  - On reset: FIFO empty, console_valid=0, console_data=0, console_overflow=0, test_passed=0, test_failed=0, test_code=0, cycle counter=0.
  - Reset mid-transfer flushes the FIFO immediately; no pending entry survives.
- Address decode (combinational, exact word match):
  - Hit on CONSOLE_ADDR, CONSOLE_ADDR+4, TEST_STAT_ADDR or TEST_STAT_ADDR+8 (the last only when the feature is enabled).
  - On a hit: mem_we=0, mem_wdata=0, mem_wmask=0.
  - On a miss: mem_we/mem_wdata/mem_wmask pass through from the cpu_* inputs.
  - mem_addr=cpu_addr always.
- Console write (cpu_we with cpu_addr==CONSOLE_ADDR):
  - Pushes wdata[CONSOLE_WIDTH-1:0] at the clk edge.
  - Accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise dropped and console_overflow set; it stays set until reset.
- Console pop:
  - A pop occurs when console_valid && console_ready at the edge.
  - console_data shows the head entry; it holds stable while valid && !ready.
- Push to an empty FIFO: console_valid rises the next cycle, with no combinational bypass. Push and pop on an empty FIFO cannot coincide.
- Pointers wrap modulo CONSOLE_DEPTH. Count is $clog2(CONSOLE_DEPTH)+1 bits, range 0..CONSOLE_DEPTH.
- Console status read (CONSOLE_ADDR+4): bit0 full, bit1 empty, bit2 overflow, bits[15:8] count, other bits 0. Writes are ignored.
- Console data register reads return 0.
- Test-status writes (TEST_STAT_ADDR):
  - wdata==PASS_MAGIC sets test_passed.
  - Any other value, when test_failed==0, sets test_failed and latches test_code=wdata.
  - Later failures do not overwrite test_code. Flags never clear except on reset.
- Test-status read returns {XLEN-2 zeros, test_failed, test_passed}.
- Read data:
  - cpu_rdata is combinational: the MMIO register value on a decode hit, else mem_rdata.
  - Same latency as a dmem load.

Optional Feature:
- Macro MMIO_CYCLE_COUNTER_EN.
- Defined:
  - XLEN-bit counter, increments every clk, wraps from all-ones to 0.
  - Reads at TEST_STAT_ADDR+8 return the current count.
  - Writes there load cpu_wdata, taking precedence over the increment that cycle.
- Undefined:
  - No counter logic.
  - TEST_STAT_ADDR+8 is an ordinary dmem address passed through.

Test Plan:
- Reset released; store 0x41 to 0x1000_0000 with console_ready=0 → console_valid=1 the next cycle, console_data=0x41, mem_we=0 throughout.
- 9 console stores 0x30..0x38 with ready=0, DEPTH=8 → first 8 held, console_overflow=1. Status read gives count=8, full=1. Then ready=1 → sink receives 0x30..0x37 in order, valid drops after 8 cycles.
- FIFO full; console store and pop in the same cycle → store accepted, count stays 8, overflow stays 0.
- Store 5 then 7 to 0x2000_0000, then 123456789 → test_failed=1, test_code=5, test_passed=1. Assert reset mid-sequence → all flags 0 immediately.
- Store 0xDEAD_BEEF to 0x0000_0100, then load it → mem_we=1 with wdata and mask passed through, cpu_rdata=mem_rdata=0xDEAD_BEEF.
- With MMIO_CYCLE_COUNTER_EN: write 0xFFFF_FFFE to 0x2000_0008 → reads give 0xFFFF_FFFF, then 0x0 on following cycles. Without the macro → the same address reaches dmem.
